// File: rtl/wb_arbiter_n_pkg.sv
// Shared types and helpers for the N-master Wishbone arbiter.
// Sized for up to 8 masters and 64-bit fields.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ERR   = 2'd2
    } arb_state_e;

    localparam int MAX_MASTERS = 8;
    localparam int IDX_W       = $clog2(MAX_MASTERS);
    localparam int MAX_FIELD   = 64;
    localparam int MAX_BUS     = MAX_MASTERS * MAX_FIELD;
    localparam int CNT_W       = 16;

    // Extract field idx of width w from a packed bus, zero-extended.
    function automatic logic [MAX_FIELD-1:0] get_slice(input logic [MAX_BUS-1:0] bus,
                                                       input int idx, input int w);
        logic [MAX_FIELD-1:0] r;
        r = '0;
        for (int b = 0; b < MAX_FIELD; b++) begin
            if (b < w) r[b] = bus[idx*w + b];
        end
        return r;
    endfunction

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] oh);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_MASTERS; i++) begin
            if (oh[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_arbiter_n_if.sv
// Bus bundle between N Wishbone masters, the arbiter and one slave.
// Names are relative to the arbiter: _i enters it, _o leaves it.
interface wb_arbiter_n_if #(
    parameter int N_MASTERS = 2,
    parameter int AW        = 32,
    parameter int DW        = 32
);
    localparam int SW = DW / 8;

    // Wishbone classic: a beat completes in a cycle where cyc, stb and ack are all high;
    // the initiator holds cyc/stb/adr/dat/sel/we stable until that cycle.
    logic [N_MASTERS-1:0]    m_cyc_i;
    logic [N_MASTERS-1:0]    m_stb_i;
    logic [N_MASTERS-1:0]    m_we_i;
    logic [N_MASTERS*SW-1:0] m_sel_i;
    logic [N_MASTERS*AW-1:0] m_adr_i;
    logic [N_MASTERS*DW-1:0] m_dat_i;
    logic [N_MASTERS-1:0]    m_ack_o;
    logic [N_MASTERS-1:0]    m_err_o;
    logic [DW-1:0]           m_dat_o;
    logic                    s_cyc_o;
    logic                    s_stb_o;
    logic                    s_we_o;
    logic [SW-1:0]           s_sel_o;
    logic [AW-1:0]           s_adr_o;
    logic [DW-1:0]           s_dat_o;
    logic                    s_ack_i;
    logic [DW-1:0]           s_dat_i;

    // slave: the arbiter itself (slave of the N masters); master: the surrounding system.
    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, s_ack_i, s_dat_i,
        output m_ack_o, m_err_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o
    );

    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, s_ack_i, s_dat_i,
        input  m_ack_o, m_err_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o
    );

endinterface

// File: rtl/wb_arbiter_n_rr_picker.sv
// Combinational one-hot winner selector: fixed priority (index 0 first)
// or round-robin starting one above the last winner.
module rr_picker
    import wb_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    input  logic             rr_mode_i,
    output logic [N-1:0]     gnt_o
);

    logic found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req_i[(rr_mode_i ? (int'(ptr_i) + 1 + k) : k) % N]) begin
                gnt_o[(rr_mode_i ? (int'(ptr_i) + 1 + k) : k) % N] = 1'b1;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter_n.sv
// N-master to 1-slave Wishbone classic arbiter with burst beat limit
// and per-transfer ack timeout reported as an error to the stalled owner.
module wb_arbiter_n
    import wb_arb_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int RR_MODE   = 1,
    parameter int MAX_BEATS = 0,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    wb_arbiter_n_if.slave        bus,
    output logic [N_MASTERS-1:0] grant_o,
    output logic                 timeout_o,
    output arb_state_e           state_o
);

    localparam int SW = DW / 8;

    arb_state_e           state_q, state_d;
    logic [N_MASTERS-1:0] grant_q, grant_d, pick;
    logic [IDX_W-1:0]     ptr_q, ptr_d, gidx, pick_idx;
    logic [CNT_W-1:0]     beat_q, beat_d, to_q, to_d;
    logic                 owner_cyc, owner_stb, others_req, beat_limit, to_expire;
    logic [MAX_BUS-1:0]   sel_bus, adr_bus, dat_bus;

    rr_picker #(.N(N_MASTERS)) u_picker (
        .req_i     (bus.m_cyc_i),
        .ptr_i     (ptr_q),
        .rr_mode_i (RR_MODE != 0),
        .gnt_o     (pick)
    );

    assign gidx       = onehot_to_idx(MAX_MASTERS'(grant_q));
    assign pick_idx   = onehot_to_idx(MAX_MASTERS'(pick));
    assign sel_bus    = MAX_BUS'(bus.m_sel_i);
    assign adr_bus    = MAX_BUS'(bus.m_adr_i);
    assign dat_bus    = MAX_BUS'(bus.m_dat_i);
    assign owner_cyc  = |(bus.m_cyc_i & grant_q);
    assign owner_stb  = owner_cyc && (|(bus.m_stb_i & grant_q));
    assign others_req = |(bus.m_cyc_i & ~grant_q);
    assign beat_limit = (MAX_BEATS > 0) && bus.s_ack_i && others_req &&
                        (beat_q >= CNT_W'(MAX_BEATS - 1));
    // An ack in the expiring cycle completes the beat, so it suppresses the error.
    assign to_expire  = (TIMEOUT > 0) && owner_stb && !bus.s_ack_i &&
                        (to_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        bus.s_cyc_o = 1'b0;
        bus.s_stb_o = 1'b0;
        bus.s_we_o  = 1'b0;
        bus.s_sel_o = '0;
        bus.s_adr_o = '0;
        bus.s_dat_o = '0;
        bus.m_ack_o = '0;
        bus.m_err_o = '0;
        timeout_o   = 1'b0;
        if (state_q == GRANT) begin
            bus.s_cyc_o = owner_cyc;
            bus.s_stb_o = owner_stb;
            bus.s_we_o  = |(bus.m_we_i & grant_q);
            bus.s_sel_o = SW'(get_slice(sel_bus, int'(gidx), SW));
            bus.s_adr_o = AW'(get_slice(adr_bus, int'(gidx), AW));
            bus.s_dat_o = DW'(get_slice(dat_bus, int'(gidx), DW));
            bus.m_ack_o = grant_q & {N_MASTERS{bus.s_ack_i}};
        end else if (state_q == ERR) begin
            bus.m_err_o = grant_q;
            timeout_o   = 1'b1;
        end
    end

    assign bus.m_dat_o = bus.s_dat_i;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        beat_d  = beat_q;
        to_d    = to_q;
        unique case (state_q)
            IDLE: begin
                if (|bus.m_cyc_i) begin
                    state_d = GRANT;
                    grant_d = pick;
                    ptr_d   = pick_idx;
                    beat_d  = '0;
                    to_d    = '0;
                end
            end
            GRANT: begin
                if (bus.s_ack_i && (beat_q != '1)) beat_d = beat_q + CNT_W'(1);
                if (owner_stb && !bus.s_ack_i) to_d = to_q + CNT_W'(1);
                else                           to_d = '0;
                if (to_expire) begin
                    state_d = ERR;
                end else if (!owner_cyc || beat_limit) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            ERR: begin
                state_d = IDLE;
                grant_d = '0;
                beat_d  = '0;
                to_d    = '0;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= IDX_W'(N_MASTERS - 1);
            beat_q  <= '0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            beat_q  <= beat_d;
            to_q    <= to_d;
        end
    end

    assign grant_o = grant_q;
    assign state_o = state_q;

endmodule
